regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side front end for the processor register file. Merges the core's same-cycle result sources (ALU, load-immediate, CPP/CYY copy) with data-memory load returns.
- Drives the single register-file write port (WriteEn/Waddr/DataIn) through a registered output stage.
- Tracks in-flight loads in an in-order destination queue, exposes a per-register busy scoreboard and generates the core stall.

Parameters:
W, 8, data path width
A, 4, register address width (2**A registers)
DEPTH, 4, max outstanding loads (power of 2, >=2)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-low; 0 clears all state immediately
AluValid  in  1  ALU result write request
AluAddr  in  A  ALU destination register
AluData  in  W  ALU result
ImmValid  in  1  load-immediate write request; destination fixed r3
ImmData  in  W  immediate value
CopyValid  in  1  CPP/CYY write request
CopySel  in  1  0 = CPP (dest r1), 1 = CYY (dest r2)
CopyData  in  W  source register value already read by core
LoadIssue  in  1  data-memory load issued; reserves destination
LoadAddr  in  A  load destination register
MemValid  in  1  load data returning (in order, never back-pressured)
MemData  in  W  returned load data
CheckEn  in  1  core operand/destination hazard check enable
CheckAddr  in  A  register the core is about to read or write
WriteEn  out  1  register-file write enable (registered)
Waddr  out  A  register-file write address (registered)
DataIn  out  W  register-file write data (registered)
Busy  out  2**A  bit i = 1 while any queued load targets ri
Stall  out  1  core must hold current instruction and inputs
Error  out  1  sticky: MemValid with empty load queue

Behaviour:
- Reset (Reset=0, async): WriteEn=0, Waddr=0, DataIn=0, queue empty, hold empty, Busy=0, Stall=0, Error=0. Reset mid-load discards all queued entries; late MemValid after reset sets Error.
- Core sources are mutually exclusive (at most one of AluValid/ImmValid/CopyValid per cycle). More than one = protocol violation, behaviour unspecified.
- Core request accepted only when Stall=0.
- Load queue:
  - FIFO of DEPTH destination addresses; head/tail pointers wrap modulo DEPTH; separate count 0..DEPTH.
  - Accepted LoadIssue pushes LoadAddr.
  - MemValid pops the head and produces write (head addr, MemData).
  - Pop and push in the same cycle are both allowed, except push is refused when count==DEPTH at cycle start.
- Busy[i] = OR over valid queue entries of (entry==i). Combinational from queue state only, so duplicate pending loads to one register stay busy until the last returns.
- Write-port arbitration, evaluated each cycle:
  - MemValid wins.
  - Else, if the hold register is full, the hold entry drains.
  - Else, an accepted core request writes.
  - The winner appears on WriteEn/Waddr/DataIn at the next rising edge (1-cycle latency). WriteEn=0 for cycles with no winner.
- Hold register (1 entry): an accepted core request that loses to MemValid is captured (addr, data). It drains the first cycle without MemValid.
- Stall (combinational) = hold full OR (CheckEn AND Busy[CheckAddr]) OR (LoadIssue AND count==DEPTH).
  - While Stall=1, all core requests and LoadIssue are ignored.
  - MemValid is never ignored.
- MemValid with count==0: no write, no pop, Error set until reset.
- Destination mapping: Imm -> r3; CopySel 0 -> r1, 1 -> r2; ALU -> AluAddr. r0 is an ordinary writable register.

Test Plan:
- Reset=0 while two loads are queued, then released; MemValid, MemData=0x11 -> no WriteEn, Error=1, Busy=0.
- ImmValid, ImmData=0x5A -> next edge WriteEn=1, Waddr=3, DataIn=0x5A. CopyValid, CopySel=1, CopyData=0x07 -> Waddr=2, DataIn=0x07.
- LoadIssue r5, then CheckEn, CheckAddr=5 -> Stall=1, Busy[5]=1. MemValid, MemData=0xC3 -> Waddr=5, DataIn=0xC3, Busy[5]=0, Stall drops.
- AluValid r4=0x22 same cycle as MemValid for pending r6=0x99:
  - cycle+1: Waddr=6, DataIn=0x99, Stall=1.
  - cycle+2: Waddr=4, DataIn=0x22, Stall=0.
- Issue DEPTH=4 loads to r1, r1, r7, r9 -> fifth LoadIssue gives Stall=1.
  - Pop + push in the same cycle at count=3 -> count stays 3.
  - Busy[1] stays 1 until the second r1 return.
  - Pointer wrap verified over 10 issue/return pairs with correct in-order addresses.

Source files
------------

// File: rtl/regfile_writeback.sv
// Register-file write front end: merges core results with in-order load returns
// onto one registered write port, tracks pending load destinations and raises Stall.
module regfile_writeback #(
    parameter int W     = 8,
    parameter int A     = 4,
    parameter int DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AluValid,
    input  logic [A-1:0]      AluAddr,
    input  logic [W-1:0]      AluData,
    input  logic              ImmValid,
    input  logic [W-1:0]      ImmData,
    input  logic              CopyValid,
    input  logic              CopySel,
    input  logic [W-1:0]      CopyData,
    input  logic              LoadIssue,
    input  logic [A-1:0]      LoadAddr,
    input  logic              MemValid,
    input  logic [W-1:0]      MemData,
    input  logic              CheckEn,
    input  logic [A-1:0]      CheckAddr,
    output logic              WriteEn,
    output logic [A-1:0]      Waddr,
    output logic [W-1:0]      DataIn,
    output logic [(1<<A)-1:0] Busy,
    output logic              Stall,
    output logic              Error
);
    localparam int PW = $clog2(DEPTH);

    logic [A-1:0] q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic [DEPTH-1:0] ent_vld;

    logic hold_full;
    logic [A-1:0] hold_addr;
    logic [W-1:0] hold_data;

    logic core_req, accept, push, pop, full, empty;
    logic [A-1:0] core_addr;
    logic [W-1:0] core_data;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // An entry is live when its distance from head is below count.
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        logic [PW-1:0] off;
        assign off        = PW'(k) - head;
        assign ent_vld[k] = ({1'b0, off} < count);
    end

    always_comb begin
        Busy = '0;
        for (int k = 0; k < DEPTH; k++)
            if (ent_vld[k]) Busy[q[k]] = 1'b1;
    end

    always_comb begin
        core_addr = AluAddr;
        core_data = AluData;
        if (ImmValid) begin
            core_addr = A'(3);
            core_data = ImmData;
        end else if (CopyValid) begin
            core_addr = CopySel ? A'(2) : A'(1);
            core_data = CopyData;
        end
    end

    assign core_req = AluValid | ImmValid | CopyValid;
    assign Stall    = hold_full | (CheckEn & Busy[CheckAddr]) | (LoadIssue & full);
    assign accept   = core_req & ~Stall;
    assign push     = LoadIssue & ~Stall;
    assign pop      = MemValid & ~empty;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            WriteEn   <= 1'b0;
            Waddr     <= '0;
            DataIn    <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            Error     <= 1'b0;
            for (int k = 0; k < DEPTH; k++) q[k] <= '0;
        end else begin
            WriteEn <= 1'b0;
            if (pop) begin
                WriteEn <= 1'b1;
                Waddr   <= q[head];
                DataIn  <= MemData;
                // A core result displaced by the load return parks in hold.
                if (accept) begin
                    hold_full <= 1'b1;
                    hold_addr <= core_addr;
                    hold_data <= core_data;
                end
            end else if (hold_full) begin
                WriteEn   <= 1'b1;
                Waddr     <= hold_addr;
                DataIn    <= hold_data;
                hold_full <= 1'b0;
            end else if (accept) begin
                WriteEn <= 1'b1;
                Waddr   <= core_addr;
                DataIn  <= core_data;
            end

            if (push) begin
                q[tail] <= LoadAddr;
                tail    <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);

            if (MemValid && empty) Error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: vector table for core sources plus directed
// load/hold/full/wrap sequences, all writes cross-checked against a scoreboard queue.
module tb_regfile_writeback;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        AluValid, ImmValid, CopyValid, CopySel, LoadIssue, MemValid, CheckEn;
    logic [3:0]  AluAddr, LoadAddr, CheckAddr;
    logic [7:0]  AluData, ImmData, CopyData, MemData;
    logic        WriteEn, Stall, Error;
    logic [3:0]  Waddr;
    logic [7:0]  DataIn;
    logic [15:0] Busy;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    regfile_writeback #(.W(8), .A(4), .DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData),
        .ImmValid(ImmValid), .ImmData(ImmData),
        .CopyValid(CopyValid), .CopySel(CopySel), .CopyData(CopyData),
        .LoadIssue(LoadIssue), .LoadAddr(LoadAddr),
        .MemValid(MemValid), .MemData(MemData),
        .CheckEn(CheckEn), .CheckAddr(CheckAddr),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Busy(Busy), .Stall(Stall), .Error(Error)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       alu, imm, copy, csel;
        logic [3:0] aaddr;
        logic [7:0] data;
        logic [3:0] eaddr;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        AluValid = 0; ImmValid = 0; CopyValid = 0; CopySel = 0;
        LoadIssue = 0; MemValid = 0; CheckEn = 0;
        AluAddr = 0; LoadAddr = 0; CheckAddr = 0;
        AluData = 0; ImmData = 0; CopyData = 0; MemData = 0;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every observed write must be the next expected one.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge Clk);
            if (WriteEn === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got addr=%0d data=%0h, required no write", Waddr, DataIn);
                end else begin
                    e = exp_q.pop_front();
                    if ({Waddr, DataIn} !== e) begin
                        errors++;
                        $display("FAIL sb_write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                                 Waddr, DataIn, e[11:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] wa[11];
        vecs[0] = '{alu:0, imm:1, copy:0, csel:0, aaddr:4'd0,  data:8'h5A, eaddr:4'd3};
        vecs[1] = '{alu:0, imm:0, copy:1, csel:1, aaddr:4'd0,  data:8'h07, eaddr:4'd2};
        vecs[2] = '{alu:0, imm:0, copy:1, csel:0, aaddr:4'd0,  data:8'h3C, eaddr:4'd1};
        vecs[3] = '{alu:1, imm:0, copy:0, csel:0, aaddr:4'd0,  data:8'hA5, eaddr:4'd0};
        vecs[4] = '{alu:1, imm:0, copy:0, csel:0, aaddr:4'd15, data:8'hFF, eaddr:4'd15};
        vecs[5] = '{alu:1, imm:0, copy:0, csel:0, aaddr:4'd9,  data:8'h00, eaddr:4'd9};

        idle();
        Reset = 0;
        tick(); tick();
        chk("rst_WriteEn", WriteEn, 0);
        chk("rst_Waddr", Waddr, 0);
        chk("rst_DataIn", DataIn, 0);
        chk("rst_Busy", Busy, 0);
        chk("rst_Stall", Stall, 0);
        chk("rst_Error", Error, 0);
        Reset = 1;

        // Reset while loads are pending, then a stray return.
        LoadIssue = 1; LoadAddr = 2; tick();
        LoadAddr = 3; tick();
        idle(); #1;
        chk("pend_Busy", Busy, 16'h000C);
        Reset = 0; #1;
        chk("midrst_Busy", Busy, 0);
        chk("midrst_Stall", Stall, 0);
        tick();
        Reset = 1;
        MemValid = 1; MemData = 8'h11; tick(); idle();
        chk("late_WriteEn", WriteEn, 0);
        chk("late_Error", Error, 1);
        chk("late_Busy", Busy, 0);
        Reset = 0; #1;
        chk("err_clr", Error, 0);
        tick();
        Reset = 1;

        // Core source table.
        for (int i = 0; i < 6; i++) begin
            idle();
            AluValid = vecs[i].alu; ImmValid = vecs[i].imm; CopyValid = vecs[i].copy;
            CopySel = vecs[i].csel; AluAddr = vecs[i].aaddr;
            AluData = vecs[i].data; ImmData = vecs[i].data; CopyData = vecs[i].data;
            expect_wr(vecs[i].eaddr, vecs[i].data);
            tick();
            chk("vec_WriteEn", WriteEn, 1);
            chk("vec_Waddr", Waddr, vecs[i].eaddr);
            chk("vec_DataIn", DataIn, vecs[i].data);
        end
        idle(); tick();
        chk("idle_WriteEn", WriteEn, 0);

        // Load hazard on r5; a core request during the stall is dropped.
        LoadIssue = 1; LoadAddr = 5; tick(); idle();
        CheckEn = 1; CheckAddr = 5; AluValid = 1; AluAddr = 8; AluData = 8'hEE; #1;
        chk("haz_Stall", Stall, 1);
        chk("haz_Busy5", Busy[5], 1);
        tick();
        chk("haz_drop", WriteEn, 0);
        AluValid = 0;
        MemValid = 1; MemData = 8'hC3; expect_wr(5, 8'hC3);
        tick(); MemValid = 0; #1;
        chk("ld_Waddr", Waddr, 5);
        chk("ld_DataIn", DataIn, 8'hC3);
        chk("ld_Busy5", Busy[5], 0);
        chk("ld_Stall", Stall, 0);
        idle();

        // Core write collides with load return: load first, core via hold.
        LoadIssue = 1; LoadAddr = 6; tick(); idle();
        AluValid = 1; AluAddr = 4; AluData = 8'h22; MemValid = 1; MemData = 8'h99;
        expect_wr(6, 8'h99); expect_wr(4, 8'h22);
        tick(); idle(); #1;
        chk("col1_Waddr", Waddr, 6);
        chk("col1_DataIn", DataIn, 8'h99);
        chk("col1_Stall", Stall, 1);
        tick();
        chk("col2_Waddr", Waddr, 4);
        chk("col2_DataIn", DataIn, 8'h22);
        chk("col2_Stall", Stall, 0);
        tick();
        chk("col3_WriteEn", WriteEn, 0);

        // Fill the queue, refuse the fifth, pop+push at count 3.
        LoadIssue = 1;
        LoadAddr = 1; tick();
        LoadAddr = 1; tick();
        LoadAddr = 7; tick();
        LoadAddr = 9; tick();
        LoadAddr = 2; #1;
        chk("full_Stall", Stall, 1);
        chk("full_Busy", Busy, 16'h0282);
        tick(); idle();
        MemValid = 1; MemData = 8'hA1; expect_wr(1, 8'hA1); tick(); idle(); #1;
        chk("dup_Busy1", Busy[1], 1);
        MemValid = 1; MemData = 8'hA2; expect_wr(1, 8'hA2);
        LoadIssue = 1; LoadAddr = 3; #1;
        chk("pp_Stall", Stall, 0);
        tick(); idle(); #1;
        chk("pp_Busy1", Busy[1], 0);
        chk("pp_Busy3", Busy[3], 1);
        LoadIssue = 1; LoadAddr = 4; #1;
        chk("cnt3_Stall", Stall, 0);
        tick();
        LoadAddr = 5; #1;
        chk("cnt4_Stall", Stall, 1);
        tick(); idle();
        MemValid = 1;
        MemData = 8'hB0; expect_wr(7, 8'hB0); tick();
        MemData = 8'hB1; expect_wr(9, 8'hB1); tick();
        MemData = 8'hB2; expect_wr(3, 8'hB2); tick();
        MemData = 8'hB3; expect_wr(4, 8'hB3); tick();
        idle(); #1;
        chk("drain_Busy", Busy, 0);

        // Ten issue/return pairs, one return per cycle, pointers wrap several times.
        for (int i = 0; i < 11; i++) wa[i] = 4'($urandom_range(0, 15));
        LoadIssue = 1; LoadAddr = wa[0]; tick(); idle();
        for (int i = 0; i < 10; i++) begin
            MemValid = 1; MemData = 8'(i * 17 + 3);
            expect_wr(wa[i], 8'(i * 17 + 3));
            if (i < 9) begin
                LoadIssue = 1; LoadAddr = wa[i+1];
            end
            tick(); idle();
        end
        tick(); tick(); #1;
        chk("wrap_Busy", Busy, 0);
        chk("end_Error", Error, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
